dual_grant_arbiter: RTL
=======================

DUAL_GRANT_ARBITER -- requirements
Module: dual_grant_arbiter

Interface
REQ-001 SHALL have parameter N, default 12, number of requesters (N >= 2).
REQ-002 SHALL have parameter MAX_HOLD, default 16, maximum cycles a slot may hold a grant (MAX_HOLD >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  N  request vector; bit k = requester k.
REQ-006 SHALL have port done_i  input  2  per-slot release; bit s ends slot s grant.
REQ-007 SHALL have port gnt_o  output  N  grant vector; at most two bits set.
REQ-008 SHALL have port slot_valid_o  output  2  slot s holds a grant.
REQ-009 SHALL have port slot0_idx_o, slot1_idx_o  output  $clog2(N) each  index held by slot 0 / slot 1.
REQ-010 SHALL have port timeout_o  output  2  one-cycle pulse when slot s is force-released.

Function
REQ-011 Each slot SHALL be an FSM with states IDLE and BUSY.
REQ-012 Eligible vector SHALL be req_i with bits of indices held by BUSY slots cleared.
REQ-013 Search order SHALL be rotated round-robin: ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-014 Both slots IDLE: slot 0 SHALL take the first eligible index, slot 1 the second, in search order.
REQ-015 Exactly one slot IDLE: it SHALL take the first eligible index in search order.
REQ-016 Grant latency SHALL be one cycle: eligibility sampled at edge t, slot BUSY with idx, valid and gnt_o bit visible after edge t.
REQ-017 A slot SHALL never hold the same index as the other slot; gnt_o SHALL equal OR of one-hot(idx) of BUSY slots.
REQ-018 A BUSY slot SHALL ignore req_i deassertion and hold its grant until done_i[s] or timeout.
REQ-019 done_i[s] in BUSY SHALL return slot s to IDLE at next edge; slot SHALL not re-grant on that same edge (minimum one IDLE cycle).
REQ-020 done_i[s] in IDLE SHALL be ignored.
REQ-021 Each slot SHALL have a hold counter, cleared on grant, incremented each BUSY cycle.
REQ-022 If counter = MAX_HOLD-1 and done_i[s]=0, slot SHALL go IDLE and pulse timeout_o[s] for one cycle; done_i[s]=1 at that cycle releases without timeout.
REQ-023 On any edge issuing >=1 new grant, ptr SHALL become (last newly granted index in search order + 1) mod N; else ptr unchanged.
REQ-024 ptr wrap: index N-1 granted last SHALL set ptr to 0.
REQ-025 slot idx outputs SHALL hold last granted value while IDLE; consumers qualify with slot_valid_o.
REQ-026 All outputs SHALL be registered; no combinational path input -> output.

Reset
REQ-027 rst_n low SHALL immediately force: both slots IDLE, gnt_o=0, slot_valid_o=0, slot idx=0, timeout_o=0, counters=0, ptr=0.
REQ-028 Reset asserted mid-grant SHALL drop grants without timeout pulse; first grant after release follows REQ-016 from ptr=0.

Structure
REQ-029 Package dual_grant_arb_pkg SHALL hold slot state enum (IDLE, BUSY) and default N / MAX_HOLD constants.
REQ-030 Rotated first/second selection SHALL be one sub-module, rr_dual_pick (inputs: eligible vector, ptr; outputs: first/second index and valid), combinational, reused by the slot logic.

Verification (N=12, MAX_HOLD=16)
REQ-031 After reset, req_i=0x0C0 -> next cycle slot0 idx 6, slot1 idx 7, gnt_o=0x0C0, ptr=8.
REQ-032 ptr=8, req_i=0x101 -> slot0 idx 8, slot1 idx 0, ptr=1 (wrap path).
REQ-033 Slots hold 3 and 5, req_i=0xFFF, done_i=01 -> slot0 IDLE one cycle, then granted next eligible after ptr, never 3 or 5.
REQ-034 Slot 1 held, done_i never asserted -> after 16 BUSY cycles slot1 IDLE, timeout_o=10 for exactly one cycle.
REQ-035 Single requester req_i=0x800 continuous -> only slot 0 granted idx 11, slot1_valid_o stays 0, ptr=0.
REQ-036 rst_n low mid-grant -> all outputs 0 asynchronously, no timeout pulse, post-reset arbitration restarts at ptr 0.

Source files
------------

// File: rtl/dual_grant_arb_pkg.sv
// Shared types and default sizing for the two-slot round-robin arbiter.
package dual_grant_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_state_e;

    localparam int unsigned DEF_N        = 12;
    localparam int unsigned DEF_MAX_HOLD = 16;

endpackage

// File: rtl/dual_grant_arbiter_rr_dual_pick.sv
// Combinational rotated search: first and second set bits of elig_i starting at ptr_i.
module rr_dual_pick
    import dual_grant_arb_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0]         elig_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] first_idx_o,
    output logic                 first_vld_o,
    output logic [$clog2(N)-1:0] second_idx_o,
    output logic                 second_vld_o
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        first_idx_o  = '0;
        first_vld_o  = 1'b0;
        second_idx_o = '0;
        second_vld_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned k;
            // ptr_i < N, so one conditional subtract implements the wrap
            k = 32'(ptr_i) + i;
            if (k >= N) k = k - N;
            if (elig_i[IW'(k)]) begin
                if (!first_vld_o) begin
                    first_idx_o = IW'(k);
                    first_vld_o = 1'b1;
                end else if (!second_vld_o) begin
                    second_idx_o = IW'(k);
                    second_vld_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dual_grant_arbiter.sv
// Two-slot round-robin arbiter: each slot holds one requester until done or hold timeout.
module dual_grant_arbiter
    import dual_grant_arb_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic [1:0]           done_i,
    output logic [N-1:0]         gnt_o,
    output logic [1:0]           slot_valid_o,
    output logic [$clog2(N)-1:0] slot0_idx_o,
    output logic [$clog2(N)-1:0] slot1_idx_o,
    output logic [1:0]           timeout_o
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(MAX_HOLD);

    slot_state_e   state_q [2];
    slot_state_e   state_d [2];
    logic [IW-1:0] idx_q   [2];
    logic [IW-1:0] idx_d   [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    to_q, to_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt_q, gnt_d;

    logic [N-1:0]  held;
    logic [N-1:0]  elig;
    logic [IW-1:0] first_idx, second_idx;
    logic          first_vld, second_vld;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        held = '0;
        for (int unsigned s = 0; s < 2; s++)
            if (state_q[s] == BUSY) held[idx_q[s]] = 1'b1;
        elig = req_i & ~held;
    end

    rr_dual_pick #(.N(N)) u_pick (
        .elig_i       (elig),
        .ptr_i        (ptr_q),
        .first_idx_o  (first_idx),
        .first_vld_o  (first_vld),
        .second_idx_o (second_idx),
        .second_vld_o (second_vld)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        to_d    = '0;
        ptr_d   = ptr_q;
        gnt_d   = '0;

        for (int unsigned s = 0; s < 2; s++) begin
            if (state_q[s] == BUSY) begin
                if (done_i[s]) begin
                    state_d[s] = IDLE;
                end else if (cnt_q[s] == CW'(MAX_HOLD - 1)) begin
                    state_d[s] = IDLE;
                    to_d[s]    = 1'b1;
                end else begin
                    cnt_d[s] = cnt_q[s] + 1'b1;
                end
            end
        end

        // Grants depend on the pre-edge state, so a slot released this edge stays IDLE one cycle
        if (state_q[0] == IDLE && state_q[1] == IDLE) begin
            if (first_vld) begin
                state_d[0] = BUSY;
                idx_d[0]   = first_idx;
                cnt_d[0]   = '0;
                ptr_d      = next_ptr(first_idx);
            end
            if (second_vld) begin
                state_d[1] = BUSY;
                idx_d[1]   = second_idx;
                cnt_d[1]   = '0;
                ptr_d      = next_ptr(second_idx);
            end
        end else if (state_q[0] == IDLE && first_vld) begin
            state_d[0] = BUSY;
            idx_d[0]   = first_idx;
            cnt_d[0]   = '0;
            ptr_d      = next_ptr(first_idx);
        end else if (state_q[1] == IDLE && first_vld) begin
            state_d[1] = BUSY;
            idx_d[1]   = first_idx;
            cnt_d[1]   = '0;
            ptr_d      = next_ptr(first_idx);
        end

        for (int unsigned s = 0; s < 2; s++)
            if (state_d[s] == BUSY) gnt_d[idx_d[s]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < 2; s++) begin
                state_q[s] <= IDLE;
                idx_q[s]   <= '0;
                cnt_q[s]   <= '0;
            end
            to_q  <= '0;
            ptr_q <= '0;
            gnt_q <= '0;
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                idx_q[s]   <= idx_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            to_q  <= to_d;
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign slot_valid_o = {state_q[1] == BUSY, state_q[0] == BUSY};
    assign slot0_idx_o  = idx_q[0];
    assign slot1_idx_o  = idx_q[1];
    assign timeout_o    = to_q;

endmodule
